// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the interrupt controller.
// Optional feature macro: INT_CTRL_NEST_EN (priority-threshold nesting).
package int_ctrl_pkg;

  localparam int unsigned NIrqDefault      = 4;
  localparam logic [31:0] VecBaseDefault   = 32'h0000_0100;
  localparam logic [31:0] VecStrideDefault = 32'd16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } state_e;

  // Index of the lowest set bit (index 0 is highest priority); 32 when vec is empty.
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 32;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one interrupt line.
module irq_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic edge_o
);

  logic       s1_q, s2_q, s3_q;
  // Marks which stages hold genuine samples rather than reset zeros, so a line
  // held high across reset does not look like a fresh rising edge.
  logic [2:0] vld_q;

  // Shift the raw line through the synchronizer and delay stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      vld_q <= 3'b000;
    end else begin
      s1_q  <= irq_i;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      vld_q <= {vld_q[1:0], 1'b1};
    end
  end

  assign edge_o = s2_q & ~s3_q & vld_q[2];

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge latching, masking, fixed priority, req/ack handshake
// with the pipeline and in-service tracking until eret.
// Optional feature macro: INT_CTRL_NEST_EN enables nested service by priority threshold.
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int unsigned  N_IRQ      = NIrqDefault,
  parameter logic [31:0]  VEC_BASE   = VecBaseDefault,
  parameter logic [31:0]  VEC_STRIDE = VecStrideDefault,
  localparam int unsigned CodeW      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             in_clk,
  input  logic             in_RST,
  input  logic [N_IRQ-1:0] in_irq,
  input  logic [N_IRQ-1:0] in_INM,
  input  logic             in_IE,
  input  logic             in_safe,
  input  logic             in_int_ack,
  input  logic             in_eret,
  output logic             out_int_req,
  output logic [CodeW-1:0] out_code,
  output logic [31:0]      out_vector,
  output logic [N_IRQ-1:0] out_pending,
  output logic [N_IRQ-1:0] out_isr
);

  state_e             state_q;
  logic               int_req_q;
  logic [CodeW-1:0]   code_q;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   isr_q, isr_d;
  logic [N_IRQ-1:0]   edge_w;
  logic [N_IRQ-1:0]   elig;
  logic               elig_any;
  logic               take;
  int unsigned        thr;
  int unsigned        pick;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk_i  (in_clk),
      .rst_i  (in_RST),
      .irq_i  (in_irq[g]),
      .edge_o (edge_w[g])
    );
  end

  // Preemption threshold and highest-priority eligible candidate.
  always_comb begin
    thr = N_IRQ;
    if (isr_q != '0) begin
`ifdef INT_CTRL_NEST_EN
      thr = lowest_set(32'(isr_q));
`else
      thr = 0;
`endif
    end
    elig = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      elig[i] = pending_q[i] & ~in_INM[i] & (i < thr);
    end
    elig_any = |elig;
    pick     = lowest_set(32'(elig));
  end

  // Next pending/in-service: eret clears before ack sets; a same-cycle edge survives the ack.
  always_comb begin
    take      = (state_q == StReq) && in_int_ack;
    pending_d = pending_q;
    if (take) pending_d[code_q] = 1'b0;
    pending_d = pending_d | edge_w;

    isr_d = isr_q;
    if (in_eret) begin
`ifdef INT_CTRL_NEST_EN
      isr_d = isr_q & (isr_q - N_IRQ'(1));
`else
      isr_d = '0;
`endif
    end
    if (take) isr_d[code_q] = 1'b1;
  end

  // Pending and in-service registers.
  always_ff @(posedge in_clk or posedge in_RST) begin
    if (in_RST) begin
      pending_q <= '0;
      isr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      isr_q     <= isr_d;
    end
  end

  // Handshake FSM with registered request and code.
  always_ff @(posedge in_clk or posedge in_RST) begin
    if (in_RST) begin
      state_q   <= StIdle;
      int_req_q <= 1'b0;
      code_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_IE && in_safe && elig_any) begin
            state_q   <= StReq;
            int_req_q <= 1'b1;
            code_q    <= CodeW'(pick);
          end
        end
        StReq: begin
          // Ack wins over a simultaneous IE drop: the pipeline already took it.
          if (in_int_ack) begin
            state_q   <= StHold;
            int_req_q <= 1'b0;
          end else if (!in_IE) begin
            state_q   <= StIdle;
            int_req_q <= 1'b0;
          end
        end
        StHold: begin
          state_q <= StIdle;
        end
        default: begin
          state_q   <= StIdle;
          int_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_int_req = int_req_q;
  assign out_code    = code_q;
  assign out_vector  = VEC_BASE + (32'(code_q) * VEC_STRIDE);
  assign out_pending = pending_q;
  assign out_isr     = isr_q;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_int_controller;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] irq = '0;
  logic [N-1:0] inm = '0;
  logic         ie = 1'b0;
  logic         safe = 1'b0;
  logic         ack = 1'b0;
  logic         eret = 1'b0;
  logic         int_req;
  logic [1:0]   code;
  logic [31:0]  vector;
  logic [N-1:0] pending;
  logic [N-1:0] isr;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  int_controller dut (
    .in_clk      (clk),
    .in_RST      (rst),
    .in_irq      (irq),
    .in_INM      (inm),
    .in_IE       (ie),
    .in_safe     (safe),
    .in_int_ack  (ack),
    .in_eret     (eret),
    .out_int_req (int_req),
    .out_code    (code),
    .out_vector  (vector),
    .out_pending (pending),
    .out_isr     (isr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting, 1 requesting, 2 guard cycle after ack.
  int           m_phase;
  logic [1:0]   m_code;
  logic [N-1:0] m_pend, m_isr;
  logic [N-1:0] hist[$];  // irq samples, newest first
  int           t_thr, t_pick, t_nphase;
  logic [1:0]   t_ncode;
  logic [N-1:0] t_edges, t_nisr, t_npend;
  bit           t_take;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_code  <= 2'd0;
      m_pend  <= '0;
      m_isr   <= '0;
      hist.delete();
    end else begin
      // A rise counts once two genuine samples after reset show low then high.
      t_edges = (hist.size() >= 3) ? (hist[1] & ~hist[2]) : '0;
      hist.push_front(irq);
      if (hist.size() > 3) void'(hist.pop_back());

      t_thr = N;
      if (m_isr != 0) begin
`ifdef INT_CTRL_NEST_EN
        for (int i = N - 1; i >= 0; i--) if (m_isr[i]) t_thr = i;
`else
        t_thr = 0;
`endif
      end
      t_pick = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && !inm[i] && i < t_thr) t_pick = i;

      t_take   = (m_phase == 1) && ack;
      t_nphase = m_phase;
      t_ncode  = m_code;
      if (m_phase == 0) begin
        if (ie && safe && t_pick >= 0) begin
          t_nphase = 1;
          t_ncode  = 2'(t_pick);
        end
      end else if (m_phase == 1) begin
        if (ack) t_nphase = 2;
        else if (!ie) t_nphase = 0;
      end else begin
        t_nphase = 0;
      end

      t_nisr = m_isr;
      if (eret) begin
`ifdef INT_CTRL_NEST_EN
        for (int i = 0; i < N; i++) begin
          if (t_nisr[i]) begin
            t_nisr[i] = 1'b0;
            break;
          end
        end
`else
        t_nisr = '0;
`endif
      end
      if (t_take) t_nisr[m_code] = 1'b1;

      t_npend = m_pend;
      if (t_take) t_npend[m_code] = 1'b0;
      t_npend = t_npend | t_edges;

      m_phase <= t_nphase;
      m_code  <= t_ncode;
      m_pend  <= t_npend;
      m_isr   <= t_nisr;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req", int_req, (m_phase == 1));
      chk("m_code", code, m_code);
      chk("m_vector", vector, 32'h100 + 32'(m_code) * 32'd16);
      chk("m_pending", pending, m_pend);
      chk("m_isr", isr, m_isr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_req(input string name, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      tick();
      if (int_req) got = 1'b1;
    end
    chk(name, got, 1'b1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    chk_en = 1'b1;
    ticks(2);
    chk("rst_req", int_req, 0);
    chk("rst_code", code, 0);
    chk("rst_vector", vector, 32'h100);
    chk("rst_pending", pending, 0);
    chk("rst_isr", isr, 0);
    rst = 1'b0;
    ie = 1'b1;
    safe = 1'b1;
    ticks(4);

    // irq2 pulse: pending at +2, request at +3.
    irq[2] = 1'b1;
    tick();
    irq[2] = 1'b0;
    tick();
    chk("t1_pend_early", pending, 4'b0000);
    tick();
    chk("t1_pend", pending, 4'b0100);
    chk("t1_noreq", int_req, 0);
    tick();
    chk("t1_req", int_req, 1);
    chk("t1_code", code, 2);
    chk("t1_vector", vector, 32'h120);
    do_ack();
    chk("t1_isr", isr, 4'b0100);
    chk("t1_pend_clr", pending, 4'b0000);
    chk("t1_req_fall", int_req, 0);
    do_eret();
    chk("t1_eret", isr, 4'b0000);
    ticks(2);

    // irq1 and irq3 together: 1 first, 3 after eret.
    irq = 4'b1010;
    ticks(3);
    chk("t2_pend", pending, 4'b1010);
    irq = 4'b0000;
    tick();
    chk("t2_code1", code, 1);
    chk("t2_req1", int_req, 1);
    do_ack();
    chk("t2_isr1", isr, 4'b0010);
    chk("t2_pend3", pending, 4'b1000);
    ticks(3);
    chk("t2_blocked", int_req, 0);
    do_eret();
    wait_req("t2_req3", 5);
    chk("t2_code3", code, 3);
    chk("t2_vector3", vector, 32'h130);
    do_ack();
    do_eret();
    ticks(2);

    // Masked line stays pending until unmasked.
    inm = 4'b0001;
    irq[0] = 1'b1;
    ticks(5);
    chk("t3_pend", pending, 4'b0001);
    chk("t3_noreq", int_req, 0);
    inm = 4'b0000;
    tick();
    chk("t3_req", int_req, 1);
    chk("t3_code", code, 0);
    irq[0] = 1'b0;
    do_ack();
    do_eret();
    ticks(2);

    // Higher-priority arrival while irq2 in service.
    irq[2] = 1'b1;
    wait_req("t4_req2", 6);
    do_ack();
    chk("t4_isr2", isr, 4'b0100);
    irq = 4'b0010;
`ifdef INT_CTRL_NEST_EN
    wait_req("t4_nest_req", 8);
    chk("t4_nest_code", code, 1);
    do_ack();
    chk("t4_nest_isr", isr, 4'b0110);
    do_eret();
    chk("t4_nest_eret1", isr, 4'b0100);
    do_eret();
`else
    ticks(6);
    chk("t4_flat_noreq", int_req, 0);
    chk("t4_flat_pend", pending, 4'b0010);
    do_eret();
    wait_req("t4_flat_req", 6);
    chk("t4_flat_code", code, 1);
    do_ack();
    chk("t4_flat_isr", isr, 4'b0010);
    do_eret();
`endif
    irq = 4'b0000;
    ticks(3);

    // Withdraw request by dropping IE, then re-request.
    irq[0] = 1'b1;
    wait_req("t5_req", 6);
    ie = 1'b0;
    tick();
    chk("t5_withdrawn", int_req, 0);
    chk("t5_pend", pending, 4'b0001);
    ie = 1'b1;
    wait_req("t5_rereq", 3);
    chk("t5_code", code, 0);
    irq[0] = 1'b0;
    do_ack();
    do_eret();
    ticks(2);

    // Asynchronous reset mid-handshake; held-high line is not a new edge.
    irq[3] = 1'b1;
    wait_req("t6_req", 6);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", int_req, 0);
    chk("t6_rst_code", code, 0);
    chk("t6_rst_vector", vector, 32'h100);
    chk("t6_rst_pend", pending, 0);
    chk("t6_rst_isr", isr, 0);
    ticks(2);
    rst = 1'b0;
    ticks(8);
    chk("t6_no_edge_pend", pending, 0);
    chk("t6_no_edge_req", int_req, 0);
    irq[3] = 1'b0;
    ticks(3);
    irq[3] = 1'b1;
    wait_req("t6_new_edge", 6);
    chk("t6_code", code, 3);
    do_ack();
    do_eret();
    irq = '0;
    ticks(3);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) irq = irq ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        inm = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      ie   = ($urandom_range(0, 9) != 0);
      safe = ($urandom_range(0, 3) != 0);
      ack  = ($urandom_range(0, 1) == 0);
      eret = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 400) == 0);
      tick();
    end
    rst = 1'b0;
    ack = 1'b0;
    eret = 1'b0;
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
